// File: rtl/shift_issue_stage_if.sv
// Decode-to-execute handshake bundle for the shift/rotate issue stage.
// master = upstream/execute side driver, slave = the issue stage itself.
interface shift_issue_stage_if #(
  parameter int DEST_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic [15:0]       in_cnt_reg;
  logic [3:0]        in_imm;
  logic              in_cnt_sel;
  logic [1:0]        in_op;
  logic [DEST_W-1:0] in_dest;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_In;
  logic [3:0]        out_Cnt;
  logic [1:0]        out_Op;
  logic [DEST_W-1:0] out_dest;
  logic [15:0]       out_count;

  modport master (
    output in_valid, in_data, in_cnt_reg, in_imm, in_cnt_sel, in_op, in_dest,
           flush, out_ready,
    input  in_ready, out_valid, out_In, out_Cnt, out_Op, out_dest, out_count
  );

  modport slave (
    input  in_valid, in_data, in_cnt_reg, in_imm, in_cnt_sel, in_op, in_dest,
           flush, out_ready,
    output in_ready, out_valid, out_In, out_Cnt, out_Op, out_dest, out_count
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Two-entry skid buffer between decode and the shifter; in_ready is purely
// registered so out_ready never reaches the upstream handshake combinationally.
module shift_issue_stage #(
  parameter int DEST_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  shift_issue_stage_if.slave bus
);

  typedef struct packed {
    logic [15:0]       data;
    logic [3:0]        cnt;
    logic [1:0]        op;
    logic [DEST_W-1:0] dest;
  } op_t;

  op_t         main_q, main_d, skid_q, skid_d, in_pkt;
  logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [15:0] count_q, count_d;
  logic        in_xfer, out_xfer;
  logic [11:0] unused_cnt_hi;

  assign unused_cnt_hi = bus.in_cnt_reg[15:4];

  // Count source is resolved once, at acceptance.
  always_comb begin
    in_pkt.data = bus.in_data;
    in_pkt.cnt  = bus.in_cnt_sel ? bus.in_imm : bus.in_cnt_reg[3:0];
    in_pkt.op   = bus.in_op;
    in_pkt.dest = bus.in_dest;
  end

  assign in_xfer  = bus.in_valid & ~skid_vld_q;
  assign out_xfer = main_vld_q & bus.out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    count_d    = count_q + {15'd0, out_xfer};

    if (!main_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_xfer;
        if (in_xfer) skid_d = in_pkt;
      end else if (in_xfer) begin
        main_d     = in_pkt;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = in_pkt;
      skid_vld_d = 1'b1;
    end

    // Flush drops held and incoming work but an output taken this cycle still counts.
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      count_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      count_q    <= count_d;
    end
  end

  assign bus.in_ready  = ~skid_vld_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_In    = main_q.data;
  assign bus.out_Cnt   = main_q.cnt;
  assign bus.out_Op    = main_q.op;
  assign bus.out_dest  = main_q.dest;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed-vector bench for shift_issue_stage: accepted inputs go into an
// expectation queue, a negedge monitor pops and compares every output transfer.
module tb_shift_issue_stage;
  localparam int DEST_W = 3;

  typedef struct packed {
    logic [15:0]       data;
    logic [3:0]        cnt;
    logic [1:0]        op;
    logic [DEST_W-1:0] dest;
  } exp_t;

  typedef struct {
    logic [15:0]       data;
    logic [15:0]       creg;
    logic [3:0]        imm;
    logic              sel;
    logic [1:0]        op;
    logic [DEST_W-1:0] dest;
    logic [3:0]        ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  logic last_acc;
  vec_t vecs[8];

  shift_issue_stage_if #(.DEST_W(DEST_W)) bus ();

  shift_issue_stage #(.DEST_W(DEST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: output transfers pop the queue; held outputs must not change.
  exp_t held;
  logic prev_hold = 1'b0;
  always @(negedge clk) begin
    exp_t act;
    act = '{bus.out_In, bus.out_Cnt, bus.out_Op, bus.out_dest};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && bus.out_valid) chk("hold_stable", 32'(act), 32'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(act), 32'hDEAD);
        else chk("out_pkt", 32'(act), 32'(exp_q.pop_front()));
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      held      = act;
    end
  end

  task automatic cyc();
    logic acc;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && !bus.flush && !rst;
    @(posedge clk);
    #1;
    if (rst || bus.flush) exp_q.delete();
    if (acc) exp_q.push_back(cur_exp);
    last_acc = acc;
  endtask

  task automatic set_in(input int i);
    bus.in_data    = vecs[i].data;
    bus.in_cnt_reg = vecs[i].creg;
    bus.in_imm     = vecs[i].imm;
    bus.in_cnt_sel = vecs[i].sel;
    bus.in_op      = vecs[i].op;
    bus.in_dest    = vecs[i].dest;
    cur_exp        = '{vecs[i].data, vecs[i].ecnt, vecs[i].op, vecs[i].dest};
  endtask

  task automatic send(input int i, input int maxc);
    int k;
    set_in(i);
    bus.in_valid = 1'b1;
    for (k = 0; k < maxc; k++) begin
      cyc();
      if (last_acc) break;
    end
    if (k == maxc) chk("accept_timeout", 32'(k), 32'(maxc + 1));
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h8001, 16'h0000, 4'h3, 1'b1, 2'b10, 3'd1, 4'h3};
    vecs[1] = '{16'h1234, 16'hFFF5, 4'hA, 1'b0, 2'b00, 3'd2, 4'h5};
    vecs[2] = '{16'hF0F0, 16'h0007, 4'hC, 1'b1, 2'b01, 3'd7, 4'hC};
    vecs[3] = '{16'h0F0F, 16'h123E, 4'h1, 1'b0, 2'b11, 3'd0, 4'hE};
    vecs[4] = '{16'hAAAA, 16'h0000, 4'hF, 1'b1, 2'b10, 3'd3, 4'hF};
    vecs[5] = '{16'h5555, 16'hFFFF, 4'h0, 1'b0, 2'b01, 3'd4, 4'hF};
    vecs[6] = '{16'hC3C3, 16'h0010, 4'h9, 1'b0, 2'b00, 3'd5, 4'h0};
    vecs[7] = '{16'h7FFE, 16'h0000, 4'h8, 1'b1, 2'b11, 3'd6, 4'h8};

    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    set_in(0);
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_In", 32'(bus.out_In), 32'd0);
    chk("rst_out_Cnt", 32'(bus.out_Cnt), 32'd0);
    chk("rst_out_Op", 32'(bus.out_Op), 32'd0);
    chk("rst_out_dest", 32'(bus.out_dest), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);

    // One-cycle latency, immediate count
    bus.out_ready = 1'b1;
    send(0, 4);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_In", 32'(bus.out_In), 32'h8001);
    chk("lat_out_Cnt", 32'(bus.out_Cnt), 32'h3);
    chk("lat_out_Op", 32'(bus.out_Op), 32'h2);
    chk("lat_count_before", 32'(bus.out_count), 32'd0);
    cyc();
    chk("lat_count_after", 32'(bus.out_count), 32'd1);
    chk("lat_drained", 32'(bus.out_valid), 32'd0);

    // Register count source uses only the low nibble
    send(1, 4);
    chk("reg_cnt", 32'(bus.out_Cnt), 32'h5);
    cyc();
    chk("reg_count", 32'(bus.out_count), 32'd2);

    // Back-to-back stream
    for (int i = 2; i <= 5; i++) send(i, 4);
    repeat (3) cyc();
    chk("stream_count", 32'(bus.out_count), 32'd6);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: A in main, B in skid, C refused
    bus.out_ready = 1'b0;
    send(6, 4);
    send(7, 4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_main_A", 32'(bus.out_In), 32'hC3C3);
    set_in(0);
    bus.in_valid = 1'b1;
    cyc();
    chk("bp_C_refused", 32'(last_acc), 32'd0);
    chk("bp_main_A_hold", 32'(bus.out_In), 32'hC3C3);
    bus.out_ready = 1'b1;
    send(0, 6);
    repeat (4) cyc();
    chk("bp_count", 32'(bus.out_count), 32'd9);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Flush with both entries full and an incoming op
    bus.out_ready = 1'b0;
    send(1, 4);
    send(2, 4);
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    set_in(3);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_count", 32'(bus.out_count), 32'd9);
    cyc();
    chk("fl_dropped", 32'(bus.out_valid), 32'd0);

    // Output taken in the flush cycle still counts
    send(3, 4);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flx_count", 32'(bus.out_count), 32'd10);
    chk("flx_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream with both entries valid
    bus.out_ready = 1'b0;
    send(4, 4);
    send(5, 4);
    set_in(6);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_In", 32'(bus.out_In), 32'd0);
    chk("mrst_out_Cnt", 32'(bus.out_Cnt), 32'd0);
    chk("mrst_out_Op", 32'(bus.out_Op), 32'd0);
    chk("mrst_out_dest", 32'(bus.out_dest), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_count", 32'(bus.out_count), 32'd0);

    // Counter wrap: 65535 transfers, then one more
    bus.out_ready = 1'b1;
    set_in(7);
    bus.in_valid = 1'b1;
    repeat (65535) cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    chk("wrap_ffff", 32'(bus.out_count), 32'h0000FFFF);
    send(0, 4);
    repeat (2) cyc();
    chk("wrap_zero", 32'(bus.out_count), 32'h00000000);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 Parameter DEST_W, default 3, SHALL set the destination register tag width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  SHALL mark a valid decoded shift/rotate operation from decode.
REQ-005 in_ready  output  1  SHALL indicate that the stage accepts the input this cycle.
REQ-006 in_data  input  16  SHALL carry the operand to be shifted.
REQ-007 in_cnt_reg  input  16  SHALL carry the register-sourced count; only bits [3:0] are used.
REQ-008 in_imm  input  4  SHALL carry the immediate count.
REQ-009 in_cnt_sel  input  1  SHALL select the count source: 1 = in_imm, 0 = in_cnt_reg[3:0].
REQ-010 in_op  input  2  SHALL carry the shift op code: 00 rotate-left, 01 shift-left, 10 shift-right-arithmetic, 11 shift-right-logical.
REQ-011 in_dest  input  DEST_W  SHALL carry the write-back register tag.
REQ-012 flush  input  1  SHALL discard all held and incoming operations.
REQ-013 out_valid  output  1  SHALL mark a valid operation presented to the shifter.
REQ-014 out_ready  input  1  SHALL indicate that the execute stage consumes the output this cycle.
REQ-015 out_In  output  16, out_Cnt  output  4, out_Op  output  2, out_dest  output  DEST_W  SHALL drive the shifter In/Cnt/Op ports and the tag.
REQ-016 out_count  output  16  SHALL report the number of completed output transfers.

Function
REQ-017 Storage SHALL be a 2-entry skid buffer: main register (drives out_*) and skid register, each with a valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, driven from a register only, with no combinational path from out_ready.
REQ-019 An input transfer SHALL occur when in_valid AND in_ready; an output transfer SHALL occur when out_valid AND out_ready.
REQ-020 The captured count SHALL be in_cnt_sel ? in_imm : in_cnt_reg[3:0], resolved at input transfer; in_data, in_op and in_dest SHALL be captured unmodified.
REQ-021 When main is empty or an output transfer occurs, main SHALL load from skid if skid_valid, else from the input if an input transfer occurs, else main_valid SHALL clear.
REQ-022 When main is valid, no output transfer occurs and an input transfer occurs, the input SHALL load into skid.
REQ-023 When main loads from skid and an input transfer occurs in the same cycle, the input SHALL load into skid, so ordering is preserved.
REQ-024 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-025 out_* data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Operations SHALL leave the stage in strict acceptance order; none SHALL be duplicated or dropped except by flush or rst.
REQ-027 Flush SHALL clear main_valid and skid_valid on the next edge; an input accepted in the flush cycle SHALL be dropped; in_ready SHALL be 1 the cycle after flush.
REQ-028 An output transfer coinciding with flush SHALL still count in out_count.
REQ-029 out_count SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-030 Data registers SHALL only load on a valid load event; when invalid, contents are don't-care but SHALL NOT be X after reset.

Reset
REQ-031 On rst=1: main_valid=0, skid_valid=0, out_valid=0, in_ready=1 from the next cycle, out_In=0, out_Cnt=0, out_Op=0, out_dest=0, out_count=0.
REQ-032 rst SHALL take priority over flush and all transfers; an in-flight operation at reset SHALL be lost without counting.

Verification
REQ-033 Empty stage, in_valid=1, in_data=16'h8001, in_cnt_sel=1, in_imm=4'h3, in_op=2'b10, out_ready=1 -> next cycle out_valid=1, out_In=16'h8001, out_Cnt=3, out_Op=2'b10, out_count increments 1 cycle later.
REQ-034 in_cnt_sel=0, in_cnt_reg=16'hFFF5 -> out_Cnt=4'h5.
REQ-035 out_ready=0, three back-to-back inputs A,B,C -> A held in main, B in skid, in_ready=0, C not accepted; raise out_ready -> outputs A,B,C in order, no loss.
REQ-036 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_count unchanged.
REQ-037 Preload out_count via 65535 transfers, then one more transfer -> out_count=16'h0000.
REQ-038 rst asserted mid-stream with both entries valid -> next cycle out_valid=0, all outputs 0, in_ready=1.
